hazard_unit: RTL and testbench

Pipeline hazard controller for the RV32I 5-stage core. It produces the per-operand forwarding selects consumed by the execution unit and the load-use stall and branch flush controls for the front end. It keeps its own shadow of the destination-register state of the EX, MEM and WB stages so that every select is registered and aligned with the instruction occupying EX.

---
 rtl/riscv_defs.sv | 28 ++
 rtl/fwd_select.sv | 35 +++
 rtl/hazard_unit.sv | 120 ++++++++++++
 tb/tb_hazard_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared definitions for the RV32I core: operand-forward encodings and the
// hazard-tracking shadow slot.
`default_nettype none

package riscv_defs;

  localparam int NB_REG_ADDR = 5;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic [NB_REG_ADDR-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
  } hz_slot_t;

  // True when the slot holds a live producer of architectural register src.
  function automatic logic slot_writes(input hz_slot_t slot,
                                       input logic [NB_REG_ADDR-1:0] src);
    return slot.valid & slot.reg_write & (slot.rd == src) & (slot.rd != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_select.sv
// Producer match and priority encoder for one EX source operand.
`default_nettype none

module fwd_select
  import riscv_defs::*;
(
  input  logic [NB_REG_ADDR-1:0] src,
  input  logic                   use_src,
  input  hz_slot_t               ex_slot,
  input  hz_slot_t               mem_slot,
  output logic [1:0]             sel,
  output logic                   ex_hit
);

  logic mem_hit;
  logic unused_bits;

  assign ex_hit  = use_src & slot_writes(ex_slot, src);
  assign mem_hit = use_src & slot_writes(mem_slot, src);

  // The younger producer holds the newer value, so it wins.
  always_comb begin
    sel = FWD_NONE;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

  assign unused_bits = ex_slot.mem_read ^ mem_slot.mem_read;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: registered forward selects, load-use stall,
// branch flush and stall/flush event counters.
`default_nettype none

module hazard_unit #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_COUNT    = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [NB_REG_ADDR-1:0] i_id_rs1,
  input  logic [NB_REG_ADDR-1:0] i_id_rs2,
  input  logic                   i_id_use_rs1,
  input  logic                   i_id_use_rs2,
  input  logic [NB_REG_ADDR-1:0] i_id_rd,
  input  logic                   i_id_reg_write,
  input  logic                   i_id_mem_read,
  input  logic                   i_branch_taken,
  output logic [1:0]             o_forward_rs1,
  output logic [1:0]             o_forward_rs2,
  output logic                   o_stall,
  output logic                   o_flush,
  output logic [NB_COUNT-1:0]    o_stall_count,
  output logic [NB_COUNT-1:0]    o_flush_count
);

  import riscv_defs::*;

  hz_slot_t   ex_q;
  hz_slot_t   mem_q;
  hz_slot_t   wb_q;
  hz_slot_t   id_entry;

  logic [1:0] sel_rs1;
  logic [1:0] sel_rs2;
  logic       ex_hit_rs1;
  logic       ex_hit_rs2;
  logic       load_use;
  logic       id_bubble;
  logic       unused_wb;

  fwd_select u_fwd_rs1 (
    .src      (i_id_rs1),
    .use_src  (i_id_use_rs1),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (sel_rs1),
    .ex_hit   (ex_hit_rs1)
  );

  fwd_select u_fwd_rs2 (
    .src      (i_id_rs2),
    .use_src  (i_id_use_rs2),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (sel_rs2),
    .ex_hit   (ex_hit_rs2)
  );

  // A load in EX has no data until MEM, so its consumer must wait one cycle.
  assign load_use  = i_id_valid & ex_q.mem_read & (ex_hit_rs1 | ex_hit_rs2);
  assign o_flush   = i_branch_taken;
  assign o_stall   = load_use & ~i_branch_taken;
  assign id_bubble = o_stall | o_flush | ~i_id_valid;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = ~id_bubble;
    id_entry.rd        = i_id_rd;
    id_entry.reg_write = i_id_reg_write;
    id_entry.mem_read  = i_id_mem_read;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_forward_rs1 <= FWD_NONE;
      o_forward_rs2 <= FWD_NONE;
    end else if (id_bubble) begin
      o_forward_rs1 <= FWD_NONE;
      o_forward_rs2 <= FWD_NONE;
    end else begin
      o_forward_rs1 <= sel_rs1;
      o_forward_rs2 <= sel_rs2;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_stall_count <= '0;
      o_flush_count <= '0;
    end else begin
      if (o_stall) begin
        o_stall_count <= o_stall_count + NB_COUNT'(1);
      end
      if (o_flush) begin
        o_flush_count <= o_flush_count + NB_COUNT'(1);
      end
    end
  end

  // Writeback is covered by the write-first register file; the slot is
  // kept only so the shadow mirrors the full pipeline.
  assign unused_wb = ^wb_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a randomized
// run against an instruction-history reference model.
`default_nettype none

module tb_hazard_unit;

  localparam int NB_REG_ADDR = 5;
  localparam int NB_COUNT    = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                id_valid = 1'b0;
  logic [4:0]          id_rs1 = '0;
  logic [4:0]          id_rs2 = '0;
  logic                id_use_rs1 = 1'b0;
  logic                id_use_rs2 = 1'b0;
  logic [4:0]          id_rd = '0;
  logic                id_reg_write = 1'b0;
  logic                id_mem_read = 1'b0;
  logic                branch_taken = 1'b0;
  logic [1:0]          forward_rs1;
  logic [1:0]          forward_rs2;
  logic                stall;
  logic                flush;
  logic [NB_COUNT-1:0] stall_count;
  logic [NB_COUNT-1:0] flush_count;

  int errors = 0;
  int checks = 0;

  instr_t hist[$];

  hazard_unit #(.NB_REG_ADDR(NB_REG_ADDR), .NB_COUNT(NB_COUNT)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_use_rs1   (id_use_rs1),
    .i_id_use_rs2   (id_use_rs2),
    .i_id_rd        (id_rd),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_read  (id_mem_read),
    .i_branch_taken (branch_taken),
    .o_forward_rs1  (forward_rs1),
    .o_forward_rs2  (forward_rs2),
    .o_stall        (stall),
    .o_flush        (flush),
    .o_stall_count  (stall_count),
    .o_flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    instr_t t;
    t.valid = v; t.rd = rd; t.rw = rw; t.mr = mr;
    t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    return t;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.valid = ($urandom % 8) != 0;
    t.rd    = 5'($urandom_range(0, 3));
    t.rs1   = 5'($urandom_range(0, 3));
    t.rs2   = 5'($urandom_range(0, 3));
    t.u1    = 1'($urandom % 2);
    t.u2    = 1'($urandom % 2);
    t.rw    = ($urandom % 4) != 0;
    t.mr    = t.rw && (($urandom % 3) == 0);
    return t;
  endfunction

  // Source of a value: the nearest older in-flight writer, if any.
  function automatic logic [1:0] ref_fwd(input logic [4:0] s, input logic u);
    if (!u || s == 0) return 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (hist[d].valid && hist[d].rw && hist[d].rd == s) return (d == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic issue(input instr_t t, input logic br);
    @(negedge clk);
    id_valid = t.valid; id_rs1 = t.rs1; id_rs2 = t.rs2;
    id_use_rs1 = t.u1; id_use_rs2 = t.u2; id_rd = t.rd;
    id_reg_write = t.rw; id_mem_read = t.mr; branch_taken = br;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (forward_rs1 !== 2'b00) begin errors++; $display("FAIL reset_fwd1: got %b expected 00", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b00) begin errors++; $display("FAIL reset_fwd2: got %b expected 00", forward_rs2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_scount: got %0d expected 0", stall_count); end
    checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL reset_fcount: got %0d expected 0", flush_count); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL first_cycle_stall: got %b expected 0", stall); end
  endtask

  task automatic test_ex_forward();
    do_reset();
    issue(mk(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 1'b0);
    issue(mk(1, 5'd6, 1, 0, 5'd5, 1, 5'd3, 1), 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL exfwd_stall: got %b expected 0", stall); end
    issue(nop(), 1'b0);
    checks++; if (forward_rs1 !== 2'b10) begin errors++; $display("FAIL exfwd_rs1: got %b expected 10", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b00) begin errors++; $display("FAIL exfwd_rs2: got %b expected 00", forward_rs2); end
  endtask

  task automatic test_wb_forward();
    do_reset();
    issue(mk(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 1'b0);
    issue(nop(), 1'b0);
    issue(mk(1, 5'd7, 1, 0, 5'd0, 1, 5'd5, 1), 1'b0);
    issue(nop(), 1'b0);
    checks++; if (forward_rs1 !== 2'b00) begin errors++; $display("FAIL wbfwd_rs1: got %b expected 00", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b01) begin errors++; $display("FAIL wbfwd_rs2: got %b expected 01", forward_rs2); end
    issue(mk(1, 5'd0, 1, 0, 5'd0, 1, 5'd0, 0), 1'b0);
    issue(mk(1, 5'd8, 1, 0, 5'd0, 1, 5'd0, 1), 1'b0);
    issue(nop(), 1'b0);
    checks++; if (forward_rs1 !== 2'b00) begin errors++; $display("FAIL x0_rs1: got %b expected 00", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b00) begin errors++; $display("FAIL x0_rs2: got %b expected 00", forward_rs2); end
  endtask

  task automatic test_load_use();
    instr_t use_i;
    use_i = mk(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
    do_reset();
    issue(mk(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0), 1'b0);
    issue(use_i, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL lu_flush: got %b expected 0", flush); end
    issue(use_i, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b expected 0", stall); end
    checks++; if (forward_rs1 !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd: got %b expected 00", forward_rs1); end
    issue(nop(), 1'b0);
    checks++; if (forward_rs1 !== 2'b01) begin errors++; $display("FAIL lu_rs1: got %b expected 01", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b01) begin errors++; $display("FAIL lu_rs2: got %b expected 01", forward_rs2); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_scount: got %0d expected 1", stall_count); end
  endtask

  task automatic test_youngest();
    do_reset();
    issue(mk(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 1'b0);
    issue(mk(1, 5'd5, 1, 0, 5'd1, 1, 5'd3, 1), 1'b0);
    issue(mk(1, 5'd9, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
    issue(nop(), 1'b0);
    checks++; if (forward_rs1 !== 2'b10) begin errors++; $display("FAIL young_rs1: got %b expected 10", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b10) begin errors++; $display("FAIL young_rs2: got %b expected 10", forward_rs2); end
  endtask

  task automatic test_flush_over_stall();
    do_reset();
    issue(mk(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0), 1'b0);
    issue(mk(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b1);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fos_flush: got %b expected 1", flush); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fos_stall: got %b expected 0", stall); end
    issue(nop(), 1'b0);
    checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL fos_fcount: got %0d expected 1", flush_count); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL fos_scount: got %0d expected 0", stall_count); end
    checks++; if (forward_rs1 !== 2'b00) begin errors++; $display("FAIL fos_fwd: got %b expected 00", forward_rs1); end
  endtask

  task automatic test_reset_midstream();
    instr_t use_i;
    use_i = mk(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
    do_reset();
    issue(mk(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0), 1'b0);
    issue(use_i, 1'b0);
    issue(use_i, 1'b0);
    issue(mk(1, 5'd7, 1, 0, 5'd6, 1, 5'd6, 1), 1'b0);
    issue(mk(1, 5'd5, 1, 1, 5'd7, 1, 5'd7, 1), 1'b0);
    checks++; if (forward_rs1 !== 2'b10) begin errors++; $display("FAIL mid_pre_fwd: got %b expected 10", forward_rs1); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL mid_pre_scount: got %0d expected 1", stall_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (forward_rs1 !== 2'b00 || forward_rs2 !== 2'b00) begin errors++; $display("FAIL mid_fwd: got %b/%b expected 00/00", forward_rs1, forward_rs2); end
    checks++; if (stall !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL mid_ctl: got %b/%b expected 0/0", stall, flush); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL mid_scount: got %0d expected 0", stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1), 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_first_stall: got %b expected 0", stall); end
    issue(mk(1, 5'd6, 1, 0, 5'd5, 1, 5'd3, 1), 1'b0);
    issue(nop(), 1'b0);
    checks++; if (forward_rs1 !== 2'b10) begin errors++; $display("FAIL mid_post_rs1: got %b expected 10", forward_rs1); end
    checks++; if (forward_rs2 !== 2'b00) begin errors++; $display("FAIL mid_post_rs2: got %b expected 00", forward_rs2); end
  endtask

  task automatic test_random();
    instr_t              cur;
    instr_t              enter;
    logic                br;
    logic                e_stall;
    logic [1:0]          e_f1;
    logic [1:0]          e_f2;
    logic [NB_COUNT-1:0] sc;
    logic [NB_COUNT-1:0] fc;
    do_reset();
    hist = {};
    hist.push_back(nop());
    hist.push_back(nop());
    e_f1 = 2'b00; e_f2 = 2'b00; sc = '0; fc = '0;
    cur = rand_instr();
    for (int c = 0; c < 400; c++) begin
      br = ($urandom % 8) == 0;
      issue(cur, br);
      e_stall = !br && cur.valid && hist[0].valid && hist[0].mr && hist[0].rw && hist[0].rd != 0 &&
                ((cur.u1 && cur.rs1 == hist[0].rd) || (cur.u2 && cur.rs2 == hist[0].rd));
      checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, e_stall); end
      checks++; if (flush !== br) begin errors++; $display("FAIL rnd_flush c=%0d: got %b expected %b", c, flush, br); end
      checks++; if (forward_rs1 !== e_f1) begin errors++; $display("FAIL rnd_fwd1 c=%0d: got %b expected %b", c, forward_rs1, e_f1); end
      checks++; if (forward_rs2 !== e_f2) begin errors++; $display("FAIL rnd_fwd2 c=%0d: got %b expected %b", c, forward_rs2, e_f2); end
      checks++; if (stall_count !== sc) begin errors++; $display("FAIL rnd_scount c=%0d: got %0d expected %0d", c, stall_count, sc); end
      checks++; if (flush_count !== fc) begin errors++; $display("FAIL rnd_fcount c=%0d: got %0d expected %0d", c, flush_count, fc); end
      if (e_stall) sc = sc + 1'b1;
      if (br) fc = fc + 1'b1;
      enter = (e_stall || br || !cur.valid) ? nop() : cur;
      e_f1 = enter.valid ? ref_fwd(cur.rs1, cur.u1) : 2'b00;
      e_f2 = enter.valid ? ref_fwd(cur.rs2, cur.u2) : 2'b00;
      hist.push_front(enter);
      void'(hist.pop_back());
      if (!e_stall) cur = rand_instr();
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_load_use();
    test_youngest();
    test_flush_over_stall();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
